// File: rtl/mx8_rr_arbiter.sv
// Round-robin arbiter/sequencer for an 8:1 x WIDTH mux: picks a requester, drives the
// registered mux select, captures the mux output and hands it off over valid/ready.
module mx8_rr_arbiter #(
  parameter int unsigned WIDTH      = 4,
  parameter logic [2:0]  RESET_LAST = 3'd7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       req,
  output logic [2:0]       sel,
  input  logic [WIDTH-1:0] mux_y,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       gnt,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEL  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0] state;
  logic [2:0] last;
  logic [2:0] winner;

  // Search starts one past the previous winner, so a requester that stays
  // asserted goes to the back of the queue.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      idx = last + k[2:0];
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      gnt       <= '0;
      busy      <= 1'b0;
      last      <= RESET_LAST;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (req != '0) begin
            sel   <= winner;
            busy  <= 1'b1;
            state <= SEL;
          end
        end
        SEL: begin
          out_data  <= mux_y;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            gnt       <= 8'b1 << sel;
            last      <= sel;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mx8_rr_arbiter.sv
// Bench for mx8_rr_arbiter: directed vector table, hand-written corner sequences and
// a randomized run against a transfer-level reference model; mux inputs a..h = 1..8.
module tb_mx8_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [2:0] sel;
  logic [3:0] mux_y;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] gnt;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign mux_y = {1'b0, sel} + 4'd1;

  mx8_rr_arbiter #(.WIDTH(4), .RESET_LAST(3'd7)) dut (
    .clk(clk), .reset(reset), .req(req), .sel(sel), .mux_y(mux_y),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .gnt(gnt), .busy(busy)
  );

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic [2:0] sel;
    logic       valid;
    logic [3:0] data;
    logic [7:0] gnt;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_all(input string tag, input logic [2:0] e_sel, input logic e_valid,
                           input logic [3:0] e_data, input logic [7:0] e_gnt, input logic e_busy);
    check({tag, ".sel"},   {5'd0, sel},      {5'd0, e_sel});
    check({tag, ".valid"}, {7'd0, out_valid}, {7'd0, e_valid});
    check({tag, ".data"},  {4'd0, out_data}, {4'd0, e_data});
    check({tag, ".gnt"},   gnt,              e_gnt);
    check({tag, ".busy"},  {7'd0, busy},     {7'd0, e_busy});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; out_ready = 1'b0; reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
  endtask

  function automatic vec_t v(logic [7:0] r, logic rd, logic [2:0] s, logic vl,
                             logic [3:0] d, logic [7:0] g, logic b);
    vec_t x;
    x.req = r; x.rdy = rd; x.sel = s; x.valid = vl; x.data = d; x.gnt = g; x.busy = b;
    return x;
  endfunction

  // Reference model state: transfer phase, pointer and expected registered outputs.
  int         m_phase;
  int         m_last;
  logic [2:0] m_sel;
  logic       m_valid;
  logic [3:0] m_data;
  logic [7:0] m_gnt;
  logic       m_busy;

  task automatic model_reset();
    m_phase = 0; m_last = 7; m_sel = '0; m_valid = 0; m_data = '0; m_gnt = '0; m_busy = 0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic rd);
    m_gnt = '0;
    if (m_phase == 0) begin
      if (r != 0) begin
        for (int k = 1; k <= 8; k++) begin
          int i;
          i = (m_last + k) % 8;
          if (r[i]) begin m_sel = 3'(i); break; end
        end
        m_busy = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_data = 4'(int'(m_sel) + 1); m_valid = 1; m_phase = 2;
    end else if (rd) begin
      m_gnt = 8'(1 << m_sel); m_last = int'(m_sel);
      m_valid = 0; m_busy = 0; m_phase = 0;
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; out_ready = 1'b0;

    // Table: one-requester transfer, wrap past 7 after serving 2, stall, ignored pulse.
    vecs.push_back(v(8'h04,1, 3'd2,0,4'h0,8'h00,1));
    vecs.push_back(v(8'h04,1, 3'd2,1,4'h3,8'h00,1));
    vecs.push_back(v(8'h04,1, 3'd2,0,4'h3,8'h04,0));
    vecs.push_back(v(8'h03,1, 3'd0,0,4'h3,8'h00,1));
    vecs.push_back(v(8'h03,1, 3'd0,1,4'h1,8'h00,1));
    vecs.push_back(v(8'h03,1, 3'd0,0,4'h1,8'h01,0));
    vecs.push_back(v(8'h03,1, 3'd1,0,4'h1,8'h00,1));
    vecs.push_back(v(8'h03,1, 3'd1,1,4'h2,8'h00,1));
    vecs.push_back(v(8'h00,1, 3'd1,0,4'h2,8'h02,0));
    vecs.push_back(v(8'h00,1, 3'd1,0,4'h2,8'h00,0));
    vecs.push_back(v(8'h08,0, 3'd3,0,4'h2,8'h00,1));
    for (int i = 0; i < 6; i++) vecs.push_back(v(8'h00,0, 3'd3,1,4'h4,8'h00,1));
    vecs.push_back(v(8'h00,1, 3'd3,0,4'h4,8'h08,0));
    vecs.push_back(v(8'h00,1, 3'd3,0,4'h4,8'h00,0));
    vecs.push_back(v(8'h02,1, 3'd1,0,4'h4,8'h00,1));
    vecs.push_back(v(8'h10,1, 3'd1,1,4'h2,8'h00,1));
    vecs.push_back(v(8'h00,1, 3'd1,0,4'h2,8'h02,0));
    vecs.push_back(v(8'h00,1, 3'd1,0,4'h2,8'h00,0));
    vecs.push_back(v(8'h00,1, 3'd1,0,4'h2,8'h00,0));

    do_reset();
    check_all("reset", 3'd0, 0, 4'h0, 8'h00, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      req = vecs[i].req; out_ready = vecs[i].rdy;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].valid, vecs[i].data,
                vecs[i].gnt, vecs[i].busy);
    end

    // All requesting: strict rotation 0..7,0 with one transfer per three cycles.
    do_reset();
    req = 8'hFF; out_ready = 1'b1;
    for (int t = 0; t < 9; t++) begin
      logic [2:0] w;
      w = 3'(t % 8);
      step(); check_all($sformatf("ff%0d.c0", t), w, 0, (t == 0) ? 4'h0 : 4'(((t + 7) % 8) + 1), 8'h00, 1);
      step(); check_all($sformatf("ff%0d.c1", t), w, 1, 4'(w) + 4'd1, 8'h00, 1);
      step(); check_all($sformatf("ff%0d.c2", t), w, 0, 4'(w) + 4'd1, 8'(1 << w), 0);
    end

    // Reset while requester 5 waits in HOLD: immediate clear, no grant, restart at 0.
    do_reset();
    req = 8'h20; out_ready = 1'b0;
    step(); step(); step();
    check_all("hold5", 3'd5, 1, 4'h6, 8'h00, 1);
    #2 reset = 1'b1;
    #1 check_all("async_rst", 3'd0, 0, 4'h0, 8'h00, 0);
    out_ready = 1'b1;
    step();
    check_all("rst_held", 3'd0, 0, 4'h0, 8'h00, 0);
    reset = 1'b0; req = 8'hFF;
    step();
    check_all("post_rst", 3'd0, 0, 4'h0, 8'h00, 1);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] r;
      logic       rd;
      r  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom) & 8'($urandom);
      rd = ($urandom_range(0, 2) != 0);
      req = r; out_ready = rd;
      model_edge(r, rd);
      step();
      check_all($sformatf("rnd%0d", c), m_sel, m_valid, m_data, m_gnt, m_busy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mx8_rr_arbiter.md
Name: mx8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the 8-input, 4-bit multiplexer (select lines s2,s1,s0) in the ALU datapath.
- Eight requesters each present a 4-bit operand on one mux input.
- The block picks one requester fairly, drives the mux select, and registers the selected mux output.
- It hands the registered value to the downstream consumer over a valid/ready handshake and pulses a one-hot grant back to the requester once the transfer completes.

Parameters:
- WIDTH, 4, data width of the mux output and the registered result.
- RESET_LAST, 7, value loaded into the last-grant pointer at reset, so the first search starts at requester 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  request per mux input; bit i corresponds to mux input i (a=0 … h=7).
- sel  output  3  mux select; sel[2]=s2, sel[1]=s1, sel[0]=s0; registered.
- mux_y  input  WIDTH  combinational output of the 8:1 mux.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- gnt  output  8  one-hot, one-cycle pulse marking the requester whose data was accepted.
- busy  output  1  high in SEL and HOLD.

Behaviour:
- Reset (asynchronous, any state):
  - State = IDLE; sel=0; out_data=0; out_valid=0; gnt=0; busy=0; last=RESET_LAST.
  - Reset mid-transfer discards the transfer with no gnt pulse.
- State IDLE:
  - req is sampled only in this state.
  - If req==0, stay in IDLE.
  - Otherwise choose the winner as the first set bit in the order last+1, last+2, … mod 8 (wrap 7→0).
  - Load sel<=winner, busy<=1, next state SEL.
- State SEL (one cycle, lets the mux settle on the registered sel):
  - out_data<=mux_y; out_valid<=1; next state HOLD.
- State HOLD:
  - out_valid stays 1; out_data and sel are held stable.
  - On out_valid&&out_ready at the clock edge:
    - gnt<=(1<<sel) for exactly one cycle.
    - last<=sel; out_valid<=0; busy<=0; next state IDLE.
  - Without out_ready, stay in HOLD indefinitely.
- Latency and throughput:
  - req high in IDLE at edge 0 → sel valid after edge 0 → out_valid after edge 1.
  - With out_ready=1, gnt is high for the cycle after edge 2.
  - Minimum 3 cycles per transfer; the next IDLE arbitration occurs in the same cycle gnt is high.
- Request changes during SEL/HOLD have no effect on the current transfer; a dropped request still completes.
- A requester that keeps req high after its gnt is eligible again only after all other active requesters are served (round-robin fairness).
- gnt is never high outside the cycle following an accepted transfer; at most one bit is set.
- out_ready while out_valid=0 is ignored.
- sel does not change while busy=1.

Test Plan (bench models the mux combinationally: mux_y = input[sel], inputs a..h = 4'h1..4'h8):
- After reset, req=8'h01, out_ready=1 → sel=0; out_valid=1 with out_data=4'h1 one cycle later; gnt=8'h01 for exactly one cycle; then idle, busy=0.
- req=8'hFF held, out_ready=1 → grants in order 0,1,…,7,0; out_data 4'h1…4'h8,4'h1; one transfer every 3 cycles.
- After serving requester 2, req=8'b0000_0011 → next grant is requester 0 (wrap), then requester 1.
- out_ready held 0 for 5 cycles in HOLD → out_valid stays 1, out_data and sel stable, gnt=0; then out_ready=1 → single gnt pulse.
- reset asserted during HOLD (requester 5) → outputs return to reset values immediately, no gnt; with req=8'hFF after release, the first grant is requester 0.
- req=8'h10 pulsed only during SEL of a requester-1 transfer → ignored; requester 4 is served only if req is high again in IDLE.
